// File: rtl/rv32m_muldiv_iter.sv
// rtl/rv32m_muldiv_iter.sv - iterative RV32M multiply/divide unit
// Radix-2 shift-add multiply and restoring divide sharing one accumulator pair.
module rv32m_muldiv_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] operand_ra_i,
  input  logic [31:0] operand_rb_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        ready_o,
  output logic [31:0] result_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] result_q, result_d;
  logic        neg_q, neg_d;

  logic [2:0]  funct3;
  logic        is_m_op;
  logic        accept;
  logic        a_signed, b_signed;
  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic        fast;
  logic [31:0] fast_res;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] prod, prod_fix;
  logic [31:0] div_sel, fix_res;
  logic        inst_unused;

  assign funct3  = inst_i[14:12];
  assign is_m_op = (inst_i[6:0] == 7'b0110011) && (inst_i[31:25] == 7'b0000001);
  assign accept  = valid_i && is_m_op && !flush_i &&
                   ((state_q == S_IDLE) || (state_q == S_DONE));

  assign inst_unused = ^{inst_i[24:15], inst_i[11:7], div_diff[32]};

  // MULH/MULHSU/DIV/REM treat rs1 as signed; only MULH/DIV/REM treat rs2 as signed.
  assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign a_neg    = a_signed && operand_ra_i[31];
  assign b_neg    = b_signed && operand_rb_i[31];
  assign mag_a    = a_neg ? (32'd0 - operand_ra_i) : operand_ra_i;
  assign mag_b    = b_neg ? (32'd0 - operand_rb_i) : operand_rb_i;

  assign fast = funct3[2] &&
                ((operand_rb_i == 32'd0) ||
                 (!funct3[0] && (operand_ra_i == 32'h8000_0000) &&
                  (operand_rb_i == 32'hFFFF_FFFF)));

  always_comb begin
    fast_res = 32'd0;
    if (operand_rb_i == 32'd0) begin
      fast_res = funct3[1] ? operand_ra_i : 32'hFFFF_FFFF;
    end else begin
      fast_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // Multiply: multiplier shifts out of acc_lo while the product shifts in from acc_hi.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);

  // Divide: dividend shifts out of acc_lo into the partial remainder in acc_hi.
  assign div_shift = {acc_hi_q, acc_lo_q[31]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opb_q};

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_q ? (64'd0 - prod) : prod;
  assign div_sel  = op_q[1] ? acc_hi_q : acc_lo_q;

  always_comb begin
    fix_res = 32'd0;
    if (!op_q[2]) begin
      fix_res = (op_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
    end else begin
      fix_res = neg_q ? (32'd0 - div_sel) : div_sel;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    result_d = result_q;
    neg_d    = neg_q;

    case (state_q)
      S_CALC: begin
        if (!op_q[2]) begin
          acc_hi_d = mul_sum[32:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
        end else if (!div_diff[33]) begin
          acc_hi_d = div_diff[31:0];
          acc_lo_d = {acc_lo_q[30:0], 1'b1};
        end else begin
          acc_hi_d = div_shift[31:0];
          acc_lo_d = {acc_lo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
      end
    endcase

    if (accept) begin
      op_d     = funct3;
      acc_hi_d = 32'd0;
      acc_lo_d = mag_a;
      opb_d    = mag_b;
      cnt_d    = 5'd0;
      // Remainder follows the dividend; product and quotient follow the sign xor.
      neg_d    = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
      if (fast) begin
        result_d = fast_res;
        state_d  = S_DONE;
      end else begin
        state_d  = S_CALC;
      end
    end

    if (flush_i) begin
      state_d  = S_IDLE;
      cnt_d    = 5'd0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 3'd0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      opb_q    <= 32'd0;
      result_q <= 32'd0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      neg_q    <= neg_d;
    end
  end

  // Accept-cycle term keeps issue from handing over a second M op in the same cycle.
  assign busy_o   = (state_q == S_CALC) || (state_q == S_FIX) || accept;
  assign ready_o  = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_rv32m_muldiv_iter.sv
// tb/tb_rv32m_muldiv_iter.sv - self-checking bench for rv32m_muldiv_iter
// Expected results are queued at issue and popped when ready_o is seen.
module tb_rv32m_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] inst_i = 32'd0;
  logic [31:0] operand_ra_i = 32'd0;
  logic [31:0] operand_rb_i = 32'd0;
  logic        flush_i = 1'b0;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;

  int          n_tests = 0;
  int          n_fail = 0;
  int          ready_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = 32'd0;

  rv32m_muldiv_iter dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .inst_i       (inst_i),
    .operand_ra_i (operand_ra_i),
    .operand_rb_i (operand_rb_i),
    .flush_i      (flush_i),
    .busy_o       (busy_o),
    .ready_o      (ready_o),
    .result_o     (result_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ready_o === 1'b1) ready_cnt++;

  function automatic logic [31:0] mk_inst(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic        ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  task automatic drive_req(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    valid_i      = 1'b1;
    inst_i       = mk_inst(f7, f3);
    operand_ra_i = a;
    operand_rb_i = b;
  endtask

  task automatic issue_wait(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            output int lat, output logic busy_acc);
    drive_req(7'b0000001, f3, a, b);
    exp_q.push_back(ref_model(f3, a, b));
    #1 busy_acc = busy_o;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      valid_i = 1'b0;
      if (ready_o === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_pop(input string name, input int lat, input int exp_lat);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    n_tests++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d, expected %0d", name, lat, exp_lat);
    end
    n_tests++;
    if (result_o !== e) begin
      n_fail++;
      $display("FAIL %s result: got %h, expected %h", name, result_o, e);
    end
    last_result = e;
  endtask

  task automatic test_reset;
    idle_cycles(3);
    n_tests++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_values: busy=%b ready=%b result=%h, expected 0 0 00000000", busy_o, ready_o, result_o);
    end
    rst = 1'b0;
    idle_cycles(1);
  endtask

  task automatic test_mul;
    int bad_busy = 0;
    int lat = -1;
    logic busy_acc;
    drive_req(7'b0000001, 3'b000, 32'd7, 32'hFFFF_FFFD);
    exp_q.push_back(32'hFFFF_FFEB);
    #1 busy_acc = busy_o;
    n_tests++;
    if (busy_acc !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_busy_accept: got %b, expected 1", busy_acc);
    end
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      valid_i = 1'b0;
      if (ready_o === 1'b1) begin
        lat = i;
        break;
      end
      if (busy_o !== 1'b1) bad_busy++;
    end
    n_tests++;
    if (bad_busy != 0) begin
      n_fail++;
      $display("FAIL mul_busy_during: %0d cycles low, expected 0", bad_busy);
    end
    check_pop("mul_7x-3", lat, 34);
    idle_cycles(1);
    n_tests++;
    if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_ready_pulse: ready=%b busy=%b after pulse, expected 0 0", ready_o, busy_o);
    end
  endtask

  task automatic test_mulh_variants;
    int lat;
    logic b;
    issue_wait(3'b001, 32'h8000_0000, 32'h8000_0000, lat, b); check_pop("mulh_min", lat, 34);
    issue_wait(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, b); check_pop("mulhsu_ff", lat, 34);
    issue_wait(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, b); check_pop("mulhu_ff", lat, 34);
    issue_wait(3'b001, 32'hFFFF_FFF9, 32'd3, lat, b);         check_pop("mulh_neg", lat, 34);
    idle_cycles(1);
  endtask

  task automatic test_div_variants;
    int lat;
    logic b;
    issue_wait(3'b100, 32'hFFFF_FFF9, 32'd2, lat, b); check_pop("div_-7_2", lat, 34);
    issue_wait(3'b110, 32'hFFFF_FFF9, 32'd2, lat, b); check_pop("rem_-7_2", lat, 34);
    issue_wait(3'b101, 32'd100, 32'd7, lat, b);       check_pop("divu_100_7", lat, 34);
    issue_wait(3'b111, 32'd100, 32'd7, lat, b);       check_pop("remu_100_7", lat, 34);
    issue_wait(3'b110, 32'd7, 32'hFFFF_FFFE, lat, b); check_pop("rem_7_-2", lat, 34);
    idle_cycles(1);
  endtask

  task automatic test_fast_path;
    int lat;
    logic b;
    issue_wait(3'b100, 32'd5, 32'd0, lat, b);                    check_pop("div_by_zero", lat, 1);
    issue_wait(3'b111, 32'd5, 32'd0, lat, b);                    check_pop("remu_by_zero", lat, 1);
    issue_wait(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, lat, b);    check_pop("div_overflow", lat, 1);
    issue_wait(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, lat, b);    check_pop("rem_overflow", lat, 1);
    idle_cycles(1);
  endtask

  task automatic test_random;
    int lat;
    logic b;
    logic [2:0]  f3;
    logic [31:0] a, c;
    for (int i = 0; i < 12; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      c  = (i % 5 == 4) ? 32'd0 : $urandom;
      issue_wait(f3, a, c, lat, b);
      check_pop("random_op", lat, exp_latency(f3, a, c));
    end
    idle_cycles(1);
  endtask

  task automatic test_flush;
    int lat;
    int rc;
    logic b;
    rc = ready_cnt;
    drive_req(7'b0000001, 3'b101, 32'd1000, 32'd3);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      valid_i = 1'b0;
    end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_busy: got %b, expected 0", busy_o);
    end
    idle_cycles(29);
    n_tests++;
    if (ready_cnt !== rc) begin
      n_fail++;
      $display("FAIL flush_no_ready: %0d pulses, expected 0", ready_cnt - rc);
    end
    n_tests++;
    if (result_o !== last_result) begin
      n_fail++;
      $display("FAIL flush_result_held: got %h, expected %h", result_o, last_result);
    end
    issue_wait(3'b000, 32'd3, 32'd4, lat, b);
    check_pop("mul_after_flush", lat, 34);
    idle_cycles(1);
  endtask

  task automatic test_flush_valid;
    int rc;
    logic busy_acc;
    rc = ready_cnt;
    flush_i = 1'b1;
    drive_req(7'b0000001, 3'b000, 32'd5, 32'd5);
    #1 busy_acc = busy_o;
    @(posedge clk); #1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    n_tests++;
    if (busy_acc !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_wins_busy: accept=%b next=%b, expected 0 0", busy_acc, busy_o);
    end
    idle_cycles(40);
    n_tests++;
    if (ready_cnt !== rc) begin
      n_fail++;
      $display("FAIL flush_wins_ready: %0d pulses, expected 0", ready_cnt - rc);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int rc;
    logic busy_acc;
    logic b;
    issue_wait(3'b000, 32'd2, 32'd3, lat, b);
    check_pop("b2b_mul", lat, 34);
    issue_wait(3'b101, 32'd9, 32'd3, lat, busy_acc);
    n_tests++;
    if (busy_acc !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept_in_done: busy=%b, expected 1", busy_acc);
    end
    check_pop("b2b_divu", lat, 34);
    idle_cycles(1);
    rc = ready_cnt;
    drive_req(7'b0000000, 3'b000, 32'd1, 32'd2);
    #1 busy_acc = busy_o;
    @(posedge clk); #1;
    valid_i = 1'b0;
    idle_cycles(40);
    n_tests++;
    if (busy_acc !== 1'b0 || ready_cnt !== rc) begin
      n_fail++;
      $display("FAIL add_ignored: busy=%b pulses=%0d, expected 0 0", busy_acc, ready_cnt - rc);
    end
  endtask

  task automatic test_reset_mid_op;
    int rc;
    drive_req(7'b0000001, 3'b011, 32'hFFFF_0000, 32'h0001_FFFF);
    idle_cycles(1);
    valid_i = 1'b0;
    idle_cycles(5);
    rst = 1'b1;
    #1;
    n_tests++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op: busy=%b ready=%b result=%h, expected 0 0 00000000", busy_o, ready_o, result_o);
    end
    idle_cycles(2);
    rst = 1'b0;
    rc = ready_cnt;
    idle_cycles(40);
    n_tests++;
    if (ready_cnt !== rc) begin
      n_fail++;
      $display("FAIL reset_no_ready: %0d pulses, expected 0", ready_cnt - rc);
    end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_mulh_variants;
    test_div_variants;
    test_fast_path;
    test_random;
    test_flush;
    test_flush_valid;
    test_back_to_back;
    test_reset_mid_op;
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
